// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: multi-cycle instruction fetch and decode stage.
// Fetches 16-bit instructions over a req/ack handshake, holds each one in an
// instruction register and splits it into opcode, 12-bit immediate and the
// 2-bit format code that feeds sign_extend.
// Optional feature macro: IFD_HALT_EN. When defined, instruction 16'hFFFF
// parks the core in HALT (left only by reset). When undefined, there is no
// HALT state, halted is tied low and 16'hFFFF decodes as a normal instruction.
module instr_fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [11:0] imm,
  output logic [1:0]  SignalIn,
  output logic        dec_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE
`ifdef IFD_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        w_accept;
  logic        w_latch_ir;
  logic        w_halt_instr;

  // The halt opcode only exists when the feature is built in.
`ifdef IFD_HALT_EN
  assign w_halt_instr = (r_ir == 16'hFFFF);
`else
  assign w_halt_instr = 1'b0;
`endif

  // ir captures memory data only on an acknowledged fetch; stray acks elsewhere are ignored.
  assign w_latch_ir = (r_state == S_FETCH) && mem_ack;

  // State register; asynchronous reset returns the machine to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and accept-cycle detection.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a
    // missing branch would infer a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  if (mem_ack) w_next_state = S_DECODE;
      S_DECODE: begin
        // Stall wins over a simultaneous branch: nothing moves while stalled.
        if (!stall) begin
          w_accept = 1'b1;
`ifdef IFD_HALT_EN
          if (w_halt_instr) w_next_state = S_HALT;
          else              w_next_state = S_FETCH;
`else
          w_next_state = S_FETCH;
`endif
        end
      end
`ifdef IFD_HALT_EN
      S_HALT:   w_next_state = S_HALT;
`endif
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Program counter: redirect or sequential advance (wrapping) on accept; frozen on halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_accept && !w_halt_instr) begin
      r_pc <= branch_taken ? branch_target : (r_pc + 16'd1);
    end
  end

  // Instruction register: loaded on the acknowledged fetch, held through DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_ir <= 16'h0000;
    else if (w_latch_ir) r_ir <= mem_rdata;
  end

  // All outputs are decoded from registered state only.
  assign mem_req   = (r_state == S_FETCH);
  assign dec_valid = (r_state == S_DECODE);
`ifdef IFD_HALT_EN
  assign halted    = (r_state == S_HALT);
`else
  assign halted    = 1'b0;
`endif
  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign opcode    = r_ir[15:12];
  assign imm       = r_ir[11:0];
  assign SignalIn  = r_ir[15:14];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios plus random
// stimulus, compared every cycle against a transaction-level reference model.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [11:0] imm;
  logic [1:0]  SignalIn;
  logic        dec_valid;
  logic        halted;

  int total = 0;
  int bad   = 0;

  // Reference model: what the stage is doing, what it holds, where it points.
  bit          m_waiting_start;  // just out of reset, first edge not yet seen
  bit          m_fetching;       // request outstanding to memory
  bit          m_holding;        // decoded instruction presented downstream
  bit          m_stopped;        // halted for good
  int unsigned m_pc;
  int unsigned m_ir;

  instr_fetch_decode #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .ir(ir), .opcode(opcode), .imm(imm), .SignalIn(SignalIn),
    .dec_valid(dec_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting_start = 1'b1;
    m_fetching      = 1'b0;
    m_holding       = 1'b0;
    m_stopped       = 1'b0;
    m_pc            = 0;
    m_ir            = 0;
  endtask

  // Apply the spec's rules for one rising edge given the inputs seen there.
  task automatic model_edge(input bit ack, input int unsigned rdata, input bit stl,
                            input bit bt, input int unsigned tgt);
    if (m_waiting_start) begin
      m_waiting_start = 1'b0;
      m_fetching      = 1'b1;
    end else if (m_fetching) begin
      if (ack) begin
        m_ir       = rdata;
        m_fetching = 1'b0;
        m_holding  = 1'b1;
      end
    end else if (m_holding && !stl) begin
      m_holding = 1'b0;
`ifdef IFD_HALT_EN
      if (m_ir == 16'hFFFF) begin
        m_stopped = 1'b1;
      end else begin
        m_pc       = bt ? tgt : (m_pc + 1) % 65536;
        m_fetching = 1'b1;
      end
`else
      m_pc       = bt ? tgt : (m_pc + 1) % 65536;
      m_fetching = 1'b1;
`endif
    end
  endtask

  task automatic check_all();
    check("mem_req",   {15'd0, mem_req},   {15'd0, m_fetching});
    check("mem_addr",  mem_addr,           m_pc[15:0]);
    check("pc",        pc,                 m_pc[15:0]);
    check("ir",        ir,                 m_ir[15:0]);
    check("opcode",    {12'd0, opcode},    16'(m_ir / 4096));
    check("imm",       {4'd0, imm},        16'(m_ir % 4096));
    check("SignalIn",  {14'd0, SignalIn},  16'(m_ir / 16384));
    check("dec_valid", {15'd0, dec_valid}, {15'd0, m_holding});
    check("halted",    {15'd0, halted},    {15'd0, m_stopped});
  endtask

  // One cycle: called at a falling edge, checks outputs, drives inputs,
  // advances model on the rising edge, returns at the next falling edge.
  task automatic step(input bit ack, input logic [15:0] rdata, input bit stl,
                      input bit bt, input logic [15:0] tgt);
    check_all();
    mem_ack       = ack;
    mem_rdata     = rdata;
    stall         = stl;
    branch_taken  = bt;
    branch_target = tgt;
    @(posedge clk);
    model_edge(ack, rdata, stl, bt, tgt);
    @(negedge clk);
  endtask

  task automatic rand_step();
    logic [15:0] rd;
    rd = 16'($urandom);
    if (rd == 16'hFFFF) rd = 16'hFFFE;
    step($urandom_range(0, 9) < 6, rd, $urandom_range(0, 3) == 0,
         $urandom_range(0, 2) == 0, 16'($urandom));
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // First fetch with ack held high.
    step(1'b1, 16'h41F0, 1'b0, 1'b0, 16'h0);   // IDLE
    check("first_req", {15'd0, mem_req}, 16'd1);
    check("first_addr", mem_addr, 16'h0000);
    step(1'b1, 16'h41F0, 1'b0, 1'b0, 16'h0);   // FETCH, acked
    check("tp_opcode", {12'd0, opcode}, 16'h0004);
    check("tp_imm", {4'd0, imm}, 16'h01F0);
    check("tp_sigin", {14'd0, SignalIn}, 16'h0001);
    check("tp_valid", {15'd0, dec_valid}, 16'd1);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);   // accept, no branch
    check("next_addr", mem_addr, 16'h0001);

    // Fetch waits three cycles for the ack.
    repeat (3) step(1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    check("wait_ir", ir, 16'h41F0);
    step(1'b1, 16'h2ABC, 1'b0, 1'b0, 16'h0);

    // Stall with branch asserted: stall wins.
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234);
    check("stall_pc", pc, 16'h0001);
    check("stall_ir", ir, 16'h2ABC);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0100);
    check("branch_addr", mem_addr, 16'h0100);

    // Wrap of pc from FFFF to 0000.
    step(1'b1, 16'h8123, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 16'hC0DE, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("wrap_addr", mem_addr, 16'h0000);

    // Random traffic.
    repeat (400) rand_step();

    // Reach FETCH, then assert reset mid-handshake with ack pending.
    for (int i = 0; i < 4 && !m_fetching; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("pre_rst_fetch", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Instruction 16'hFFFF.
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    check("ffff_sigin", {14'd0, SignalIn}, 16'h0003);
    check("ffff_imm", {4'd0, imm}, 16'h0FFF);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
`ifdef IFD_HALT_EN
    check("halt_flag", {15'd0, halted}, 16'd1);
    check("halt_pc", pc, 16'h0000);
    repeat (5) rand_step();
    check("halt_req", {15'd0, mem_req}, 16'd0);
`else
    check("nohalt_req", {15'd0, mem_req}, 16'd1);
    check("nohalt_addr", mem_addr, 16'h0001);
    repeat (5) rand_step();
`endif
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Multi-cycle instruction fetch and decode stage of the CPU datapath. It fetches 16-bit instructions from instruction memory with a request/acknowledge handshake, holds each one in an instruction register, and splits it into opcode and a 12-bit immediate field. It also derives the 2-bit format code that drives `sign_extend`, sitting directly upstream of it: its `imm` and `SignalIn` outputs connect straight to `sign_extend.in` and `sign_extend.SignalIn`.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_req` out 1: fetch request to instruction memory.
- `mem_addr` out 16: fetch address, always equal to `pc`.
- `mem_rdata` in 16: instruction word, valid when `mem_ack`=1.
- `mem_ack` in 1: memory acknowledge.
- `stall` in 1: downstream not ready; holds the decoded instruction.
- `branch_taken` in 1: redirect request, sampled only on the accept cycle.
- `branch_target` in 16: redirect PC.
- `pc` out 16: address of the current instruction.
- `ir` out 16: instruction register.
- `opcode` out 4: `ir[15:12]`.
- `imm` out 12: `ir[11:0]`, to `sign_extend.in`.
- `SignalIn` out 2: format code, to `sign_extend.SignalIn`.
- `dec_valid` out 1: decoded instruction is valid.
- `halted` out 1: core has stopped.

## Operation
- States: IDLE, FETCH, DECODE, HALT. Encoding is free; the state register is reset asynchronously.
- IDLE: entered on reset. The machine moves to FETCH on the next edge, unconditionally.
- FETCH:
  - `mem_req`=1.
  - On an edge with `mem_ack`=1, latch `ir`←`mem_rdata` and go to DECODE.
  - Otherwise stay in FETCH with `mem_addr` stable.
- DECODE:
  - `dec_valid`=1. `ir`, `opcode`, `imm` and `SignalIn` are held stable for the whole state.
  - The accept cycle is `dec_valid`=1 and `stall`=0.
  - On accept: `pc`←`branch_taken` ? `branch_target` : `pc`+1, then go to FETCH.
  - With `stall`=1, stay in DECODE; `branch_taken` is ignored.
- `SignalIn` = `ir[15:14]` (opcode class): 00 / 01 / 10 / 11 select the four `sign_extend` formats.
- `pc`+1 wraps from 16'hFFFF to 16'h0000.
- `mem_ack` is ignored outside FETCH.
- `mem_rdata` is ignored unless `mem_ack`=1 in FETCH.
- HALT: see Configuration. `mem_req`=0, `dec_valid`=0, `halted`=1. Left only by reset.

## Timing
- Reset values: `pc`=`RESET_PC`, `ir`=16'h0000, `opcode`=0, `imm`=0, `SignalIn`=00, `mem_req`=0, `dec_valid`=0, `halted`=0, state=IDLE.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- First `mem_req` rises in the first cycle after the first edge following `rst` deassertion.
- Fetch latency: `dec_valid` rises on the edge that samples `mem_ack`=1.
- Minimum cost is 2 cycles per instruction (FETCH with immediate ack, then DECODE with no stall).
- `mem_req` stays high continuously until acknowledged and drops on the edge that latches `ir`.
- Simultaneous `branch_taken` and `stall` in DECODE: the stall wins and `pc` is unchanged.
- `rst` asserted mid-operation (any state, including mid-handshake): all outputs return to their reset values immediately, without waiting for a clock edge. A pending `mem_ack` is discarded.

## Configuration
- `IFD_HALT_EN` defined:
  - An instruction equal to 16'hFFFF goes to HALT on the accept cycle instead of FETCH.
  - `pc` is not incremented.
  - `halted` rises on that edge.
- `IFD_HALT_EN` undefined:
  - There is no HALT state and `halted` is tied to 0.
  - 16'hFFFF decodes as a normal instruction (`SignalIn`=11, `imm`=12'hFFF).

## Test plan
- Reset release, `mem_ack` held 1, `mem_rdata`=16'h41F0:
  - `mem_addr`=0000, then `dec_valid`=1 with `opcode`=4, `imm`=12'h1F0, `SignalIn`=01.
  - Next accept fetches from `pc`=0001.
- FETCH with `mem_ack` low for 3 cycles: `mem_req` high and `mem_addr` stable all 3 cycles; `ir` unchanged until the ack.
- DECODE with `stall`=1 for 4 cycles and `branch_taken`=1 throughout:
  - `dec_valid` and `ir` held stable; `pc` unchanged.
  - Drop `stall` with `branch_taken`=1, `branch_target`=16'h0100: next `mem_addr`=0100.
- `pc`=16'hFFFF accepted without a branch: next `mem_addr`=16'h0000.
- Instruction 16'hFFFF:
  - With `IFD_HALT_EN`: `halted`=1, `mem_req` stays 0 forever.
  - Without: normal decode, `SignalIn`=11, fetch continues at `pc`+1.
- Assert `rst` in FETCH while `mem_ack`=1 is pending: `mem_req`, `dec_valid` and `pc` go to their reset values before the next edge, and `ir`=0.
